// File: rtl/pattern_sequencer_pkg.sv
// Shared pattern codes, sequencer state encoding and the
// wrap-around stepping rule for the test-pattern select.
package pattern_sequencer_pkg;

    localparam int PAT_W = 4;

    localparam logic [PAT_W-1:0] PAT_OFF     = 4'd0;
    localparam logic [PAT_W-1:0] PAT_RED     = 4'd1;
    localparam logic [PAT_W-1:0] PAT_GRN     = 4'd2;
    localparam logic [PAT_W-1:0] PAT_BLU     = 4'd3;
    localparam logic [PAT_W-1:0] PAT_CHECKER = 4'd4;
    localparam logic [PAT_W-1:0] PAT_BARS    = 4'd5;
    localparam logic [PAT_W-1:0] PAT_BORDER  = 4'd6;

    localparam logic DIR_NEXT = 1'b0;
    localparam logic DIR_PREV = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PEND,
        ST_BLANK
    } seq_state_e;

    // Code 0 is never a target: stepping wraps within 1..last
    function automatic logic [PAT_W-1:0] step_pattern(
        input logic [PAT_W-1:0] cur,
        input logic             prev,
        input logic [PAT_W-1:0] last
    );
        logic [PAT_W-1:0] nxt;
        if (prev) begin
            nxt = (cur <= PAT_W'(1)) ? last : cur - PAT_W'(1);
        end else begin
            nxt = (cur >= last) ? PAT_W'(1) : cur + PAT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Request/sync inputs and pattern-select outputs of the sequencer.
interface pattern_sequencer_if;
    import pattern_sequencer_pkg::*;

    logic             i_VSync;
    logic             i_Next;
    logic             i_Prev;
    logic             i_Auto_En;
    logic [PAT_W-1:0] o_Pattern;
    logic             o_Switched;
    logic             o_Busy;

    modport master (
        output i_VSync, i_Next, i_Prev, i_Auto_En,
        input  o_Pattern, o_Switched, o_Busy
    );

    modport slave (
        input  i_VSync, i_Next, i_Prev, i_Auto_En,
        output o_Pattern, o_Switched, o_Busy
    );

endinterface

// File: rtl/pattern_sequencer_rising_edge_detect.sv
// One-bit rising edge detector with a registered history bit;
// the history clears to low on reset.
module rising_edge_detect (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sig,
    output logic o_Rise
);

    logic r_Prev;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Prev <= 1'b0;
        end else begin
            r_Prev <= i_Sig;
        end
    end

    assign o_Rise = i_Sig & ~r_Prev;

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous pattern-select sequencer: manual next/prev,
// auto dwell advance and optional blank frames between patterns.
module pattern_sequencer
    import pattern_sequencer_pkg::*;
#(
    parameter int NUM_PATTERNS  = 7,
    parameter int FIRST_PATTERN = 1,
    parameter int DWELL_FRAMES  = 120,
    parameter int BLANK_FRAMES  = 2
) (
    input logic                i_Clk,
    input logic                i_Rst_L,
    pattern_sequencer_if.slave bus
);

    localparam int DW = $clog2(DWELL_FRAMES + 1);
    localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    // Expire one frame early: the PEND frame completes the dwell
    localparam int EXP = (DWELL_FRAMES > 1) ? DWELL_FRAMES - 2 : 0;
    localparam logic [PAT_W-1:0] LAST  = PAT_W'(NUM_PATTERNS - 1);
    localparam logic [PAT_W-1:0] FIRST = PAT_W'(FIRST_PATTERN);

    seq_state_e       r_State;
    logic             r_Dir;
    logic [DW-1:0]    r_Dwell;
    logic [BW-1:0]    r_Blank;
    logic [PAT_W-1:0] r_Cur;
    logic [PAT_W-1:0] r_Pattern;
    logic             r_Switched;
    logic             r_Busy;

    logic             w_Fs;
    logic             w_Req;
    logic             w_Dir;
    logic [PAT_W-1:0] w_Target;

    rising_edge_detect u_fs (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Sig  (bus.i_VSync),
        .o_Rise (w_Fs)
    );

    // Simultaneous next+prev cancels out
    assign w_Req    = bus.i_Next ^ bus.i_Prev;
    assign w_Dir    = w_Req ? bus.i_Prev : r_Dir;
    assign w_Target = step_pattern(r_Cur, w_Dir, LAST);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_State    <= ST_RUN;
            r_Dir      <= DIR_NEXT;
            r_Dwell    <= '0;
            r_Blank    <= '0;
            r_Cur      <= FIRST;
            r_Pattern  <= FIRST;
            r_Switched <= 1'b0;
            r_Busy     <= 1'b0;
        end else begin
            r_Switched <= 1'b0;
            unique case (r_State)
                ST_RUN: begin
                    if (w_Req) begin
                        r_Dir   <= bus.i_Prev;
                        r_Dwell <= '0;
                        r_Busy  <= 1'b1;
                        r_State <= ST_PEND;
                    end else if (!bus.i_Auto_En) begin
                        r_Dwell <= '0;
                    end else if (w_Fs) begin
                        if (r_Dwell >= DW'(EXP)) begin
                            r_Dwell <= '0;
                            r_Dir   <= DIR_NEXT;
                            r_Busy  <= 1'b1;
                            r_State <= ST_PEND;
                        end else begin
                            r_Dwell <= r_Dwell + 1'b1;
                        end
                    end
                end
                ST_PEND: begin
                    r_Dir <= w_Dir;
                    if (w_Fs) begin
                        if (BLANK_FRAMES == 0) begin
                            r_Pattern  <= w_Target;
                            r_Cur      <= w_Target;
                            r_Switched <= 1'b1;
                            r_Busy     <= 1'b0;
                            r_State    <= ST_RUN;
                        end else begin
                            r_Pattern <= PAT_OFF;
                            r_Blank   <= BW'(1);
                            r_State   <= ST_BLANK;
                        end
                    end
                end
                ST_BLANK: begin
                    r_Dir <= w_Dir;
                    if (w_Fs) begin
                        if (r_Blank == BW'(BLANK_FRAMES)) begin
                            r_Pattern  <= w_Target;
                            r_Cur      <= w_Target;
                            r_Switched <= 1'b1;
                            r_Busy     <= 1'b0;
                            r_Blank    <= '0;
                            r_State    <= ST_RUN;
                        end else begin
                            r_Blank <= r_Blank + 1'b1;
                        end
                    end
                end
                default: begin
                    r_State <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.o_Pattern  = r_Pattern;
    assign bus.o_Switched = r_Switched;
    assign bus.o_Busy     = r_Busy;

endmodule
